// File: rtl/drive_monitor.sv
// Clocked side-band monitor for a tri-state bus driver: enable register, edge
// pulses, last-driven capture and a saturating count of enabled cycles.
module drive_monitor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             cnt_clr,
   output logic             drive_active,
   output logic             drive_start,
   output logic             drive_stop,
   output logic [WIDTH-1:0] last_driven,
   output logic [CNT_W-1:0] drive_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             active_reg;
   logic             start_reg;
   logic             stop_reg;
   logic [WIDTH-1:0] last_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // Clear wins over increment; the counter parks at all-ones instead of wrapping.
   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_clr)
         cnt_next = '0;
      else if (data_en && (cnt_reg != CNT_MAX))
         cnt_next = cnt_reg + CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_reg <= 1'b0;
         start_reg  <= 1'b0;
         stop_reg   <= 1'b0;
         last_reg   <= '0;
         cnt_reg    <= '0;
      end else begin
         active_reg <= data_en;
         start_reg  <= data_en & ~active_reg;
         stop_reg   <= ~data_en & active_reg;
         if (data_en)
            last_reg <= data_in;
         cnt_reg    <= cnt_next;
      end
   end

   assign drive_active = active_reg;
   assign drive_start  = start_reg;
   assign drive_stop   = stop_reg;
   assign last_driven  = last_reg;
   assign drive_cnt    = cnt_reg;

endmodule

// File: rtl/tristate_driver.sv
// Tri-state bus driver: combinational enable-gated drive onto a shared bus,
// plus a clocked side-band monitor reporting drive activity.
module tristate_driver #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_en,
   input  logic [WIDTH-1:0] data_in,
   output tri   [WIDTH-1:0] data_out,
   output logic             drive_active,
   output logic             drive_start,
   output logic             drive_stop,
   output logic [WIDTH-1:0] last_driven,
   output logic [CNT_W-1:0] drive_cnt,
   input  logic             cnt_clr
);

   // Independent of clk and rst so the bus stays usable with the clock stopped.
   assign data_out = data_en ? data_in : {WIDTH{1'bz}};

   drive_monitor #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_monitor (
      .clk          (clk),
      .rst          (rst),
      .data_en      (data_en),
      .data_in      (data_in),
      .cnt_clr      (cnt_clr),
      .drive_active (drive_active),
      .drive_start  (drive_start),
      .drive_stop   (drive_stop),
      .last_driven  (last_driven),
      .drive_cnt    (drive_cnt)
   );

endmodule

// File: tb/tb_tristate_driver.sv
// Bench for tristate_driver: two instances and a bench probe share one bus;
// directed tables, reset corner cases and a randomized model comparison.
module tb_tristate_driver;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst = 1'b0;

   logic       en_a = 1'b0, clr_a = 1'b0;
   logic [7:0] din_a = 8'h00;
   logic       act_a, st_a, sp_a;
   logic [7:0] last_a;
   logic [15:0] cnt_a;

   logic       en_b = 1'b0, clr_b = 1'b0;
   logic [7:0] din_b = 8'h00;
   logic       act_b, st_b, sp_b;
   logic [7:0] last_b;
   logic [1:0] cnt_b;

   logic       probe_en = 1'b0;
   logic [7:0] probe_val = 8'h00;
   tri   [7:0] bus;

   assign bus = probe_en ? probe_val : 8'hzz;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = clk_run ? ~clk : clk;

   tristate_driver #(.WIDTH(8), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .data_en(en_a), .data_in(din_a), .data_out(bus),
      .drive_active(act_a), .drive_start(st_a), .drive_stop(sp_a),
      .last_driven(last_a), .drive_cnt(cnt_a), .cnt_clr(clr_a)
   );

   tristate_driver #(.WIDTH(8), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .data_en(en_b), .data_in(din_b), .data_out(bus),
      .drive_active(act_b), .drive_start(st_b), .drive_stop(sp_b),
      .last_driven(last_b), .drive_cnt(cnt_b), .cnt_clr(clr_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Released bus: the probe must be able to pull it to both all-0 and all-1.
   task automatic check_released(input string name);
      probe_en = 1'b1;
      probe_val = 8'h00; #1;
      check({name, "_z0"}, {24'h0, bus}, 32'h00);
      probe_val = 8'hFF; #1;
      check({name, "_z1"}, {24'h0, bus}, 32'hFF);
      probe_en = 1'b0; #1;
   endtask

   typedef struct {
      logic        en;
      logic [7:0]  din;
      logic        clr;
      logic        act, st, sp;
      logic [7:0]  last;
      logic [15:0] cnt;
   } vec_t;

   task automatic apply_vec(input bit on_b, input vec_t v, input int idx);
      string tag;
      tag = $sformatf("%s[%0d]", on_b ? "tblB" : "tblA", idx);
      en_a = on_b ? 1'b0 : v.en;  din_a = v.din;  clr_a = on_b ? 1'b0 : v.clr;
      en_b = on_b ? v.en : 1'b0;  din_b = v.din;  clr_b = on_b ? v.clr : 1'b0;
      @(posedge clk); #1;
      if (!on_b) begin
         check({tag, "_active"}, {31'h0, act_a}, {31'h0, v.act});
         check({tag, "_start"},  {31'h0, st_a},  {31'h0, v.st});
         check({tag, "_stop"},   {31'h0, sp_a},  {31'h0, v.sp});
         check({tag, "_last"},   {24'h0, last_a}, {24'h0, v.last});
         check({tag, "_cnt"},    {16'h0, cnt_a}, {16'h0, v.cnt});
      end else begin
         check({tag, "_active"}, {31'h0, act_b}, {31'h0, v.act});
         check({tag, "_start"},  {31'h0, st_b},  {31'h0, v.st});
         check({tag, "_stop"},   {31'h0, sp_b},  {31'h0, v.sp});
         check({tag, "_last"},   {24'h0, last_b}, {24'h0, v.last});
         check({tag, "_cnt"},    {30'h0, cnt_b}, {16'h0, v.cnt});
      end
      $display("vec %s en=%0b din=%h clr=%0b", tag, v.en, v.din, v.clr);
   endtask

   // Reference model state, index 0 = u_a (16-bit count), 1 = u_b (2-bit count).
   bit       m_prev [2];
   bit [7:0] m_last [2];
   int       m_cnt  [2];
   int       m_max  [2] = '{65535, 3};

   task automatic model_step(input int k, input bit en, input bit [7:0] din, input bit clr,
                             output bit es, output bit ep);
      es = en && !m_prev[k];
      ep = !en && m_prev[k];
      m_prev[k] = en;
      if (en) m_last[k] = din;
      if (clr) m_cnt[k] = 0;
      else if (en) m_cnt[k] = (m_cnt[k] + 1 > m_max[k]) ? m_max[k] : m_cnt[k] + 1;
   endtask

   vec_t tbl_a [7];
   vec_t tbl_b [9];

   initial begin
      tbl_a[0] = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 16'd1};
      tbl_a[1] = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 8'h34, 16'd2};
      tbl_a[2] = '{1'b1, 8'h56, 1'b0, 1'b1, 1'b0, 1'b0, 8'h56, 16'd3};
      tbl_a[3] = '{1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'h56, 16'd3};
      tbl_a[4] = '{1'b0, 8'h98, 1'b0, 1'b0, 1'b0, 1'b0, 8'h56, 16'd3};
      tbl_a[5] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 16'd0};
      tbl_a[6] = '{1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 16'd0};

      tbl_b[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 16'd1};
      tbl_b[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 16'd2};
      tbl_b[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 16'd3};
      tbl_b[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 16'd3};
      tbl_b[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 16'd3};
      tbl_b[5] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 16'd3};
      tbl_b[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 16'd0};
      tbl_b[7] = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 16'd1};
      tbl_b[8] = '{1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 16'd1};

      // Drive path with the clock stopped and reset never asserted.
      din_a = 'x; din_b = 'x; #1;
      check_released("noclk_dis");
      en_a = 1'b1; din_a = 8'h55; #1;
      check("noclk_55", {24'h0, bus}, 32'h55);
      din_a = 8'hAA; #1;
      check("noclk_AA", {24'h0, bus}, 32'hAA);
      en_a = 1'b0; #1;
      check_released("noclk_off");
      $display("txn drive-path clock stopped");

      clk_run = 1'b1;
      din_a = 8'h00; din_b = 8'h00;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_active", {31'h0, act_a}, 32'h0);
      check("rst_cnt",    {16'h0, cnt_a}, 32'h0);
      check("rst_last",   {24'h0, last_a}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) apply_vec(1'b0, tbl_a[i], i);
      for (int i = 0; i < 9; i++) apply_vec(1'b1, tbl_b[i], i);

      // Async reset mid-drive: side-band clears at once, bus keeps driving.
      en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      en_a = 1'b1; din_a = 8'hC3;
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_cnt", {16'h0, cnt_a}, 32'd2);
      #2 rst = 1'b1;
      #1;
      check("arst_active", {31'h0, act_a}, 32'h0);
      check("arst_cnt",    {16'h0, cnt_a}, 32'h0);
      check("arst_last",   {24'h0, last_a}, 32'h0);
      check("arst_b_last", {24'h0, last_b}, 32'h0);
      check("arst_b_sb",   {28'h0, act_b, st_b, sp_b, 1'b0}, 32'h0);
      check("arst_bus",    {24'h0, bus}, 32'hC3);
      @(posedge clk); #1;
      check("arst_hold_bus", {24'h0, bus}, 32'hC3);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rel_start", {31'h0, st_a}, 32'h1);
      check("rel_cnt",   {16'h0, cnt_a}, 32'd1);
      check("rel_last",  {24'h0, last_a}, 32'hC3);
      $display("txn async reset mid-drive");

      // Shared bus with two instances.
      en_a = 1'b1; din_a = 8'hA5; en_b = 1'b0; din_b = 8'h11; #1;
      check("bus_a", {24'h0, bus}, 32'hA5);
      en_a = 1'b0; en_b = 1'b1; din_b = 8'h3C; #1;
      check("bus_b", {24'h0, bus}, 32'h3C);
      en_b = 1'b0; #1;
      check_released("bus_none");
      $display("txn shared bus");

      // Randomized run against the model.
      rst = 1'b1; #1 rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_prev[k] = 1'b0; m_last[k] = 8'h00; m_cnt[k] = 0;
      end
      begin
         int sel = 0;
         bit es, ep;
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0) sel = $urandom_range(0, 2);
            din_a = 8'($urandom); din_b = 8'($urandom); probe_val = 8'($urandom);
            clr_a = ($urandom_range(0, 15) == 0);
            clr_b = ($urandom_range(0, 7) == 0);
            en_a = (sel == 1); en_b = (sel == 2); probe_en = (sel == 0);
            #1;
            check($sformatf("rnd%0d_bus", c), {24'h0, bus},
                  {24'h0, (sel == 1) ? din_a : (sel == 2) ? din_b : probe_val});
            @(posedge clk); #1;
            model_step(0, en_a, din_a, clr_a, es, ep);
            check($sformatf("rnd%0d_a_act", c), {31'h0, act_a}, {31'h0, m_prev[0]});
            check($sformatf("rnd%0d_a_edge", c), {30'h0, st_a, sp_a}, {30'h0, es, ep});
            check($sformatf("rnd%0d_a_last", c), {24'h0, last_a}, {24'h0, m_last[0]});
            check($sformatf("rnd%0d_a_cnt", c), {16'h0, cnt_a}, m_cnt[0]);
            model_step(1, en_b, din_b, clr_b, es, ep);
            check($sformatf("rnd%0d_b_act", c), {31'h0, act_b}, {31'h0, m_prev[1]});
            check($sformatf("rnd%0d_b_edge", c), {30'h0, st_b, sp_b}, {30'h0, es, ep});
            check($sformatf("rnd%0d_b_last", c), {24'h0, last_b}, {24'h0, m_last[1]});
            check($sformatf("rnd%0d_b_cnt", c), {30'h0, cnt_b}, m_cnt[1]);
            $display("rnd %0d sel=%0d a_cnt=%0d b_cnt=%0d", c, sel, cnt_a, cnt_b);
         end
      end
      probe_en = 1'b0; en_a = 1'b0; en_b = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tristate_driver.md
Name: tristate_driver

Overview:
- Parameterised tri-state bus driver: when `data_en` is high, `data_in` is driven onto `data_out`; otherwise `data_out` is released to high-impedance.
- The drive path is purely combinational and does not depend on clock or reset.
- A small clocked side-band block reports drive activity for bus arbitration and debug logic.
- Sits at the edge of a shared on-chip or board bus, one instance per bus master.

Parameters:
- WIDTH, 8, bus width in bits (at least 1).
- CNT_W, 16, width of the drive-cycle counter (at least 1).

Ports:
- clk, input, 1, side-band clock (rising edge).
- rst, input, 1, asynchronous active-high reset. Affects side-band registers only.
- data_en, input, 1, output enable, active high.
- data_in, input, WIDTH, value to drive.
- data_out, output (tri), WIDTH, bus output: `data_in` when enabled, all-Z otherwise.
- drive_active, output, 1, registered copy of `data_en`.
- drive_start, output, 1, one-cycle pulse on an enable rising edge.
- drive_stop, output, 1, one-cycle pulse on an enable falling edge.
- last_driven, output, WIDTH, last value sampled while enabled.
- drive_cnt, output, CNT_W, saturating count of enabled clock cycles.
- cnt_clr, input, 1, synchronous clear of `drive_cnt`.

Behaviour:
- Drive path:
  - `data_out = data_en ? data_in : {WIDTH{1'bz}}`.
  - Zero-cycle latency; settles within one delta/propagation time.
  - No clock, reset or register is involved.
- Enable is all-or-nothing across the whole bus. There is no per-bit enable.
- The path is valid with the clock stopped and with reset never asserted.
- If `data_en` is X or Z, `data_out` is X/Z-resolved per language semantics. No special handling.
- X bits on `data_in` while disabled never reach `data_out`; it stays all-Z.
- While enabled, bits of `data_in` pass through bit-exact, including X bits.
- Reset value of every side-band output, applied immediately while `rst` is high:
  - `drive_active` = 0
  - `drive_start` = 0
  - `drive_stop` = 0
  - `last_driven` = 0
  - `drive_cnt` = 0
- Reset does not alter `data_out`.
- Each rising `clk` with `rst` low:
  - `drive_active` <= `data_en`.
  - `drive_start` <= `data_en & ~drive_active`.
  - `drive_stop` <= `~data_en & drive_active`.
  - If `data_en`: `last_driven` <= `data_in`.
  - If `cnt_clr`: `drive_cnt` <= 0. Clear has priority over increment.
  - Else if `data_en` and `drive_cnt` is not all-ones: `drive_cnt` <= `drive_cnt` + 1.
  - Saturates at `2^CNT_W-1`; never wraps.
- Reset released mid-drive (`data_en` = 1): the first clock produces `drive_start` = 1, because `drive_active` was 0.
- Asserting `rst` mid-drive clears the side-band outputs but `data_out` keeps driving `data_in`.

Decomposition:
- No shared package is needed. WIDTH and CNT_W are local parameters of the block.
- Natural sub-module: `drive_monitor`. It holds the clocked side-band logic: enable register, edge pulses, `last_driven` capture and saturating counter.
- The top level holds only the continuous tri-state assign plus the `drive_monitor` instance.

Test Plan:
- No clock, no reset, `data_en` = 0, `data_in` = 8'hXX, wait 1 time unit -> `data_out` === 8'hZZ.
- `data_en` = 1, `data_in` = 8'h55, wait 1 -> `data_out` === 8'h55. Then `data_in` = 8'hAA, wait 1 -> `data_out` === 8'hAA. Then `data_en` = 0 -> 8'hZZ within 1.
- Pulse `rst`, then hold `data_en` = 1 for 3 clocks with `data_in` = 8'h12, 8'h34, 8'h56:
  - `drive_start` = 1 on the first clock only, then 0.
  - `drive_cnt` = 3 and `last_driven` = 8'h56.
  - Drop `data_en` -> `drive_stop` = 1 for one cycle; `last_driven` stays 8'h56.
- CNT_W = 2, `data_en` held high for 6 clocks -> `drive_cnt` counts 1, 2, 3, 3, 3, 3.
  - `cnt_clr` together with `data_en` -> `drive_cnt` = 0 on the next clock.
- Assert `rst` mid-drive with `data_en` = 1, `data_in` = 8'hC3:
  - Side-band outputs go to 0 immediately, without a clock edge.
  - `data_out` remains 8'hC3.
- Connect two instances to one wire, enable only one (8'hA5) -> bus reads 8'hA5. Disable both -> bus reads 8'hZZ.
